mem_rr_arbiter: RTL

- Round-robin arbiter sharing one single-port valid/ready SRAM (1-cycle access, 16-bit × 1024) between NUM_REQ requesters.
- Latches one requester's transaction and issues it to the memory as a one-cycle valid pulse.
- Captures read data and returns a one-cycle ready pulse to the granted requester.
- Sits between bus-side masters (CPU port, DMA, backdoor loader) and the memory instance.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_rr_arbiter_rr_pick.sv | 56 +++++
 rtl/mem_rr_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the round-robin memory arbiter:
//   - arb_state_t    : arbiter FSM state encoding (IDLE, ISSUE, WAIT, RESP)
//   - MEM_WIDTH      : data width of the shared single-port SRAM
//   - MEM_ADDR_WIDTH : address width of the shared single-port SRAM
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int MEM_WIDTH      = 16;
    localparam int MEM_ADDR_WIDTH = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_rr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Searches the request vector upward
// starting at last_grant+1, wrapping modulo NUM_REQ, and returns the first
// set bit.
// Ports:
//   req        in  NUM_REQ    request vector
//   last_grant in  IDX_WIDTH  index of the most recently served requester
//   any_req    out 1          at least one request bit is set
//   grant      out IDX_WIDTH  selected requester index (0 when any_req=0)
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [IDX_WIDTH-1:0] last_grant,
    output logic                 any_req,
    output logic [IDX_WIDTH-1:0] grant
);

    // Candidate gi is the requester at search distance gi+1 from last_grant.
    logic [IDX_WIDTH-1:0] cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0]   cand_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [IDX_WIDTH:0] sum;
            // last_grant < NUM_REQ and offset <= NUM_REQ, so one
            // conditional subtraction is enough to wrap.
            always_comb begin
                sum = {1'b0, last_grant} + (IDX_WIDTH+1)'(gi + 1);
                if (sum >= (IDX_WIDTH+1)'(NUM_REQ)) begin
                    sum = sum - (IDX_WIDTH+1)'(NUM_REQ);
                end
            end
            assign cand_idx[gi] = sum[IDX_WIDTH-1:0];
            assign cand_hit[gi] = req[cand_idx[gi]];
        end
    endgenerate

    // Nearest candidate wins: scan from the farthest down so the closest
    // hit is the last one assigned.
    always_comb begin
        any_req = 1'b0;
        grant   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                any_req = 1'b1;
                grant   = cand_idx[i];
            end
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mem_rr_arbiter
// Round-robin arbiter sharing one single-port valid/ready SRAM between
// NUM_REQ requesters. One transaction at a time: IDLE picks a requester,
// ISSUE drives a one-cycle mem_valid_o pulse, WAIT waits for mem_ready_i,
// RESP drives a one-cycle req_ready_o pulse to the served requester.
// Every access therefore takes 4 cycles.
//
// Optional build macro: MEM_ARB_TIMEOUT_EN
//   defined   : WAIT gives up after TIMEOUT cycles and completes the access
//               with err_o=1 (and req_rdata_o=0 for a read).
//   undefined : WAIT waits indefinitely, err_o is constant 0.
//
// Ports:
//   clk_i        in   clock
//   rst_i        in   synchronous active-high reset
//   req_valid_i  in   [NUM_REQ]            per-requester request
//   req_wr_rd_i  in   [NUM_REQ]            1=write, 0=read
//   req_addr_i   in   [NUM_REQ*ADDR_WIDTH] packed addresses
//   req_wdata_i  in   [NUM_REQ*WIDTH]      packed write data
//   req_ready_o  out  [NUM_REQ]            one-hot completion pulse
//   req_rdata_o  out  [WIDTH]              read data, valid with ready
//   grant_id_o   out  [IDX_WIDTH]          current / last granted index
//   err_o        out                       timeout pulse (with ready)
//   mem_valid_o  out                       to memory valid
//   mem_wr_rd_o  out                       to memory wr_rd
//   mem_addr_o   out  [ADDR_WIDTH]         to memory addr
//   mem_wdata_o  out  [WIDTH]              to memory wdata
//   mem_rdata_i  in   [WIDTH]              from memory rdata
//   mem_ready_i  in                        from memory ready
// ---------------------------------------------------------------------------
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int IDX_WIDTH  = 2,
    parameter int WIDTH      = MEM_WIDTH,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int TIMEOUT    = 15
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_wr_rd_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*WIDTH-1:0]      req_wdata_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [WIDTH-1:0]              req_rdata_o,
    output logic [IDX_WIDTH-1:0]          grant_id_o,
    output logic                          err_o,
    output logic                          mem_valid_o,
    output logic                          mem_wr_rd_o,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    output logic [WIDTH-1:0]              mem_wdata_o,
    input  logic [WIDTH-1:0]              mem_rdata_i,
    input  logic                          mem_ready_i
);

    // Requester 0 must win the first arbitration after reset.
    localparam logic [IDX_WIDTH-1:0] LAST_GRANT_RST = IDX_WIDTH'(NUM_REQ - 1);

    arb_state_t            state_reg,      state_next;
    logic [IDX_WIDTH-1:0]  last_grant_reg, last_grant_next;
    logic [IDX_WIDTH-1:0]  grant_reg,      grant_next;
    logic                  mem_valid_reg,  mem_valid_next;
    logic                  mem_wr_rd_reg,  mem_wr_rd_next;
    logic [ADDR_WIDTH-1:0] mem_addr_reg,   mem_addr_next;
    logic [WIDTH-1:0]      mem_wdata_reg,  mem_wdata_next;
    logic [NUM_REQ-1:0]    ready_reg,      ready_next;
    logic [WIDTH-1:0]      rdata_reg,      rdata_next;
    logic                  err_reg,        err_next;

    // Unpacked views of the packed request buses.
    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [WIDTH-1:0]      wdata_arr [NUM_REQ];
    // One-hot decode of the granted index, used for the ready pulse.
    logic [NUM_REQ-1:0]    grant_onehot;

    logic                  any_req;
    logic [IDX_WIDTH-1:0]  pick_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]     = req_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi]    = req_wdata_i[gi*WIDTH +: WIDTH];
            assign grant_onehot[gi] = (grant_reg == IDX_WIDTH'(gi));
        end
    endgenerate

    rr_pick #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_rr_pick (
        .req        (req_valid_i),
        .last_grant (last_grant_reg),
        .any_req    (any_req),
        .grant      (pick_idx)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    // Counts completed WAIT cycles; expiry is the edge ending cycle TIMEOUT.
    logic             wait_expired;
    assign wait_expired = (wait_cnt_reg == CNT_W'(TIMEOUT - 1));
`else
    // TIMEOUT is accepted so both builds share one interface; it has no
    // effect when the watchdog is compiled out.
    generate
        if (TIMEOUT < 1) begin : g_timeout_ignored
        end
    endgenerate
`endif

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        grant_next      = grant_reg;
        mem_valid_next  = 1'b0;
        mem_wr_rd_next  = mem_wr_rd_reg;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;
        ready_next      = '0;
        rdata_next      = rdata_reg;
        err_next        = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        wait_cnt_next   = wait_cnt_reg;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (any_req) begin
                    grant_next     = pick_idx;
                    mem_valid_next = 1'b1;
                    mem_wr_rd_next = req_wr_rd_i[pick_idx];
                    mem_addr_next  = addr_arr[pick_idx];
                    mem_wdata_next = wdata_arr[pick_idx];
                    state_next     = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                // mem_valid_o was high for exactly this cycle.
`ifdef MEM_ARB_TIMEOUT_EN
                wait_cnt_next = '0;
`endif
                state_next = ST_WAIT;
            end

            ST_WAIT: begin
                if (mem_ready_i) begin
                    if (!mem_wr_rd_reg) begin
                        rdata_next = mem_rdata_i;
                    end
                    ready_next      = grant_onehot;
                    last_grant_next = grant_reg;
                    state_next      = ST_RESP;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (wait_expired) begin
                    if (!mem_wr_rd_reg) begin
                        rdata_next = '0;
                    end
                    ready_next      = grant_onehot;
                    err_next        = 1'b1;
                    last_grant_next = grant_reg;
                    state_next      = ST_RESP;
                end else begin
                    wait_cnt_next = wait_cnt_reg + CNT_W'(1);
                end
`endif
            end

            ST_RESP: begin
                // The served requester still shows valid here, so no
                // arbitration until IDLE.
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= LAST_GRANT_RST;
            grant_reg      <= '0;
            mem_valid_reg  <= 1'b0;
            mem_wr_rd_reg  <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            ready_reg      <= '0;
            rdata_reg      <= '0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            grant_reg      <= grant_next;
            mem_valid_reg  <= mem_valid_next;
            mem_wr_rd_reg  <= mem_wr_rd_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            ready_reg      <= ready_next;
            rdata_reg      <= rdata_next;
            err_reg        <= err_next;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt_reg <= '0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
        end
    end
`endif

    assign req_ready_o = ready_reg;
    assign req_rdata_o = rdata_reg;
    assign grant_id_o  = grant_reg;
    assign err_o       = err_reg;
    assign mem_valid_o = mem_valid_reg;
    assign mem_wr_rd_o = mem_wr_rd_reg;
    assign mem_addr_o  = mem_addr_reg;
    assign mem_wdata_o = mem_wdata_reg;

endmodule
